// File: rtl/cic_pkg.sv
// Shared definitions for the cic_decim2 dual-channel CIC decimator:
// accumulator width, parameter legality and the default accumulator type.
package cic_pkg;

    // Accumulator width: input width plus log2(R) bits of growth per stage.
    function automatic int cic_rw(input int iw, input int n, input int r);
        return iw + n * $clog2(r);
    endfunction

    // Legal configurations: R a power of two in 2..1024, 1..6 stages, OW <= IW.
    function automatic bit cic_params_ok(input int iw, input int ow, input int n, input int r);
        return (r >= 2) && (r <= 1024) && ((r & (r - 1)) == 0) &&
               (n >= 1) && (n <= 6) && (ow >= 1) && (ow <= iw);
    endfunction

    localparam int CIC_RW_DEFAULT = cic_rw(16, 3, 64);

    // Signed accumulator for the default build (IW=16, N=3, R=64 -> 34 bits).
    typedef logic signed [CIC_RW_DEFAULT-1:0] cic_acc_t;

endpackage

// File: rtl/cic_decim2_if.sv
// I/Q sample stream: a valid strobe plus a signed I and Q word.
// master drives the stream, slave consumes it. No backpressure.
interface cic_decim2_if #(
    parameter int W = 16
);
    logic                valid;
    logic signed [W-1:0] xval;
    logic signed [W-1:0] yval;

    modport master (output valid, xval, yval);
    modport slave  (input  valid, xval, yval);
endinterface

// File: rtl/cic_chan.sv
// One channel of the CIC decimator: N integrators at the input rate,
// N combs at the decimated rate and the output scaling.
// Optional macro CIC_ROUND_EN: round-half-to-even instead of truncation.
import cic_pkg::*;

module cic_chan #(
    parameter int IW = 16,
    parameter int OW = 16,
    parameter int N  = 3,
    parameter int R  = 64
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic                 i_cap,
    input  logic [N:0]           i_stb,
    input  logic signed [IW-1:0] i_x,
    output logic signed [OW-1:0] o_y
);

    localparam int RW = cic_rw(IW, N, R);
    localparam int DW = RW - OW;

    typedef logic signed [RW-1:0] acc_t;

    acc_t              r_int  [N];
    acc_t              r_cin;
    acc_t              r_comb [N];
    acc_t              r_dly  [N];
    acc_t              w_comb_in [N];
    acc_t              w_x_ext;
    logic signed [OW-1:0] r_out;

    // Keep the top OW bits; the discarded DW bits are either rounded
    // half-to-even (same scheme as the mixer) or simply dropped.
    function automatic logic signed [OW-1:0] f_scale(input acc_t v);
`ifdef CIC_ROUND_EN
        logic [RW-1:0] bias;
        logic [RW-1:0] sum;
        if (v[DW])
            bias = RW'(1) << (DW - 1);
        else
            bias = (RW'(1) << (DW - 1)) - RW'(1);
        sum = v + bias;
        return sum[RW-1:DW];
`else
        return v[RW-1:DW];
`endif
    endfunction

    assign w_x_ext = acc_t'(i_x);

    // Integrator chain: each stage adds the previous stage's pre-edge value,
    // so the chain lags by N-1 samples; all hold when no sample is offered.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int k = 0; k < N; k++) r_int[k] <= '0;
        end else if (i_valid) begin
            r_int[0] <= r_int[0] + w_x_ext;
            for (int k = 1; k < N; k++) r_int[k] <= r_int[k] + r_int[k-1];
        end
    end

    // Decimation point: sample the last integrator once per frame.
    always_ff @(posedge i_clk) begin
        if (!i_reset)
            r_cin <= '0;
        else if (i_cap)
            r_cin <= r_int[N-1];
    end

    // Comb stage inputs: the captured value feeds stage 0, each comb feeds the next.
    always_comb begin
        w_comb_in[0] = r_cin;
        for (int k = 1; k < N; k++) w_comb_in[k] = r_comb[k-1];
    end

    // Comb pipeline: stage k fires one cycle after stage k-1 on its own strobe.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int k = 0; k < N; k++) begin
                r_comb[k] <= '0;
                r_dly[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (i_stb[k]) begin
                    r_comb[k] <= w_comb_in[k] - r_dly[k];
                    r_dly[k]  <= w_comb_in[k];
                end
            end
        end
    end

    // Output register: scaled last comb, held between decimated outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset)
            r_out <= '0;
        else if (i_stb[N])
            r_out <= f_scale(r_comb[N-1]);
    end

    assign o_y = r_out;

endmodule

// File: rtl/cic_decim2.sv
// Dual-channel (I/Q) CIC decimator, N-stage Hogenauer, decimation by R,
// unity gain. Owns the frame counter, the comb strobe pipeline and reset
// fan-out; the two channels are identical cic_chan instances.
// Optional macro CIC_ROUND_EN: round-half-to-even output scaling.
import cic_pkg::*;

module cic_decim2 #(
    parameter int IW = 16,
    parameter int OW = 16,
    parameter int N  = 3,
    parameter int R  = 64
) (
    input  logic          i_clk,
    input  logic          i_reset,
    cic_decim2_if.slave   i_smp,
    cic_decim2_if.master  o_smp
);

    localparam int CW = $clog2(R);

    if (!cic_params_ok(IW, OW, N, R)) begin : g_param_err
        $error("cic_decim2: illegal parameter set (R power of two 2..1024, N 1..6, OW <= IW)");
    end

    logic [CW-1:0]        r_cnt;
    logic [N:0]           r_stb;
    logic                 r_vld;
    logic                 w_cap;
    logic signed [OW-1:0] w_xout;
    logic signed [OW-1:0] w_yout;

    // Last sample of a frame: R is a power of two, so R-1 is all ones.
    assign w_cap = i_smp.valid && (&r_cnt);

    // Frame counter advances on accepted samples and wraps naturally at R.
    always_ff @(posedge i_clk) begin
        if (!i_reset)
            r_cnt <= '0;
        else if (i_smp.valid)
            r_cnt <= r_cnt + CW'(1);
    end

    // Strobe shift register: bit k enables comb stage k, bit N the output register.
    always_ff @(posedge i_clk) begin
        if (!i_reset)
            r_stb <= '0;
        else
            r_stb <= {r_stb[N-1:0], w_cap};
    end

    // Output pulse, aligned with the cycle in which the new output is visible.
    always_ff @(posedge i_clk) begin
        if (!i_reset)
            r_vld <= 1'b0;
        else
            r_vld <= r_stb[N];
    end

    cic_chan #(.IW(IW), .OW(OW), .N(N), .R(R)) u_chan_i (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_smp.valid),
        .i_cap   (w_cap),
        .i_stb   (r_stb),
        .i_x     (i_smp.xval),
        .o_y     (w_xout)
    );

    cic_chan #(.IW(IW), .OW(OW), .N(N), .R(R)) u_chan_q (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_smp.valid),
        .i_cap   (w_cap),
        .i_stb   (r_stb),
        .i_x     (i_smp.yval),
        .o_y     (w_yout)
    );

    assign o_smp.valid = r_vld;
    assign o_smp.xval  = w_xout;
    assign o_smp.yval  = w_yout;

endmodule
